// File: rtl/drw_wrt_burst_if.sv
// AXI4 write-channel bundle (AW/W/B) between the write-back stage and the frame buffer.
// The master modport is the burst engine; the slave modport is the memory side.
interface drw_wrt_burst_if;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output WDATA, WSTRB, WLAST, WVALID,
    output BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  WDATA, WSTRB, WLAST, WVALID,
    input  BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/drw_wrt_burst.sv
// Write-back stage: drains the pixel FIFO into a DST rectangle with 4 KB-safe AXI4 bursts, one outstanding.
// AW issues 2 cycles after a full burst is in the FIFO; W throttles on WREADY via a 2-entry skid. DRW_WRT_ERRLOG_EN adds ERR_CNT/ERR_ADDR.
module drw_wrt_burst #(
  parameter int BURST_MAX = 16,
  parameter int CNT_W     = 9
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             RST,
  input  logic             START,
  input  logic [31:0]      DST_ADDR,
  input  logic [10:0]      DST_WIDTH,
  input  logic [10:0]      DST_HEIGHT,
  input  logic [15:0]      DST_STRIDE,
  output logic             BUSY,
  output logic             DONE,
  output logic             WRT_FIFO_RD,
  input  logic             WRT_FIFO_VALID,
  input  logic [31:0]      WRT_FIFO_DOUT,
  input  logic [CNT_W-1:0] WRT_FIFO_DATA_CNT,
`ifdef DRW_WRT_ERRLOG_EN
  output logic [15:0]      ERR_CNT,
  output logic [31:0]      ERR_ADDR,
`endif
  drw_wrt_burst_if.master  m_axi
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_WAITD, S_AW, S_W, S_B, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        srst;
  logic [31:0] line_addr_q, cur_addr_q, awaddr_q;
  logic [15:0] stride_q;
  logic [10:0] width_q, pix_left_q, lines_left_q;
  logic [8:0]  len_q, rd_cnt_q, beat_cnt_q;
  logic [7:0]  awlen_q;
  logic        cnt_ok_q, zero_done_q, rd_infl_q;
  logic [31:0] skid_q [2];
  logic        wptr_q, rptr_q;
  logic [1:0]  skid_cnt_q;
  logic        start_ok, size_ok, push, pop, wlast, line_end, last_line;
  logic [12:0] room, len_c;

  assign srst      = !ARESETN || RST;
  assign start_ok  = START && (state_q == S_IDLE);
  assign size_ok   = (DST_WIDTH != 11'd0) && (DST_HEIGHT != 11'd0);
  assign room      = (13'd4096 - {1'b0, cur_addr_q[11:0]}) >> 2;
  assign wlast     = (beat_cnt_q == (len_q - 9'd1));
  assign push      = rd_infl_q && WRT_FIFO_VALID;
  assign pop       = m_axi.WVALID && m_axi.WREADY;
  assign line_end  = (pix_left_q == {2'b00, len_q});
  assign last_line = (lines_left_q == 11'd1);

  // Burst length: what is left of the line, capped by BURST_MAX and the next 4 KB page edge.
  always_comb begin
    len_c = {2'b00, pix_left_q};
    if (len_c > 13'(BURST_MAX)) len_c = 13'(BURST_MAX);
    if (room < len_c) len_c = room;
  end

  assign m_axi.AWADDR  = awaddr_q;
  assign m_axi.AWLEN   = awlen_q;
  assign m_axi.AWSIZE  = 3'b010;
  assign m_axi.AWBURST = 2'b01;
  assign m_axi.WSTRB   = 4'hF;
  assign m_axi.WVALID  = (skid_cnt_q != 2'd0);
  assign m_axi.WDATA   = skid_q[rptr_q];
  assign m_axi.WLAST   = m_axi.WVALID && wlast;

  always_ff @(posedge ACLK) begin
    if (srst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    BUSY          = (state_q != S_IDLE);
    DONE          = zero_done_q;
    WRT_FIFO_RD   = 1'b0;
    m_axi.AWVALID = 1'b0;
    m_axi.BREADY  = 1'b0;
    case (state_q)
      S_IDLE:  if (start_ok && size_ok) state_d = S_CALC;
      S_CALC:  state_d = S_WAITD;
      S_WAITD: if (cnt_ok_q) state_d = S_AW;
      S_AW: begin
        m_axi.AWVALID = 1'b1;
        if (m_axi.AWREADY) state_d = S_W;
      end
      S_W: begin
        // Reads in flight count against the skid so a returning word always has a slot.
        WRT_FIFO_RD = (({1'b0, skid_cnt_q} + {2'b00, rd_infl_q}) < 3'd2) && (rd_cnt_q < len_q);
        if (pop && wlast) state_d = S_B;
      end
      S_B: begin
        m_axi.BREADY = 1'b1;
        if (m_axi.BVALID) state_d = (line_end && last_line) ? S_DONE : S_CALC;
      end
      S_DONE: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DRW_WRT_ERRLOG_EN
  logic [15:0] err_cnt_q;
  logic [31:0] err_addr_q;
  assign ERR_CNT  = err_cnt_q;
  assign ERR_ADDR = err_addr_q;

  always_ff @(posedge ACLK) begin
    if (srst || start_ok) begin
      err_cnt_q  <= 16'd0;
      err_addr_q <= 32'd0;
    end else if (state_q == S_B && m_axi.BVALID &&
                 (m_axi.BRESP == 2'b10 || m_axi.BRESP == 2'b11)) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      if (err_cnt_q == 16'd0)    err_addr_q <= awaddr_q;
    end
  end
`endif

  always_ff @(posedge ACLK) begin
    if (srst) begin
      line_addr_q  <= 32'd0;
      cur_addr_q   <= 32'd0;
      awaddr_q     <= 32'd0;
      awlen_q      <= 8'd0;
      stride_q     <= 16'd0;
      width_q      <= 11'd0;
      pix_left_q   <= 11'd0;
      lines_left_q <= 11'd0;
      len_q        <= 9'd0;
      rd_cnt_q     <= 9'd0;
      beat_cnt_q   <= 9'd0;
      cnt_ok_q     <= 1'b0;
      zero_done_q  <= 1'b0;
      rd_infl_q    <= 1'b0;
      skid_q[0]    <= 32'd0;
      skid_q[1]    <= 32'd0;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
      skid_cnt_q   <= 2'd0;
    end else begin
      zero_done_q <= start_ok && !size_ok;
      rd_infl_q   <= WRT_FIFO_RD;
      // Registered so the length compare never sees a stale len from the previous burst.
      cnt_ok_q    <= (state_q == S_WAITD) && (32'(WRT_FIFO_DATA_CNT) >= 32'(len_q));

      if (start_ok && size_ok) begin
        line_addr_q  <= DST_ADDR;
        cur_addr_q   <= DST_ADDR;
        stride_q     <= DST_STRIDE;
        width_q      <= DST_WIDTH;
        pix_left_q   <= DST_WIDTH;
        lines_left_q <= DST_HEIGHT;
      end

      if (state_q == S_CALC) begin
        len_q      <= 9'(len_c);
        rd_cnt_q   <= 9'd0;
        beat_cnt_q <= 9'd0;
      end

      if (state_q == S_WAITD && cnt_ok_q) begin
        awaddr_q <= cur_addr_q;
        awlen_q  <= 8'(len_q - 9'd1);
      end

      if (WRT_FIFO_RD) rd_cnt_q <= rd_cnt_q + 9'd1;
      if (push) begin
        skid_q[wptr_q] <= WRT_FIFO_DOUT;
        wptr_q         <= ~wptr_q;
      end
      if (pop) begin
        rptr_q     <= ~rptr_q;
        beat_cnt_q <= beat_cnt_q + 9'd1;
      end
      case ({push, pop})
        2'b10:   skid_cnt_q <= skid_cnt_q + 2'd1;
        2'b01:   skid_cnt_q <= skid_cnt_q - 2'd1;
        default: skid_cnt_q <= skid_cnt_q;
      endcase

      if (state_q == S_B && m_axi.BVALID) begin
        if (line_end) begin
          line_addr_q  <= line_addr_q + {16'h0000, stride_q};
          cur_addr_q   <= line_addr_q + {16'h0000, stride_q};
          pix_left_q   <= width_q;
          lines_left_q <= lines_left_q - 11'd1;
        end else begin
          cur_addr_q <= cur_addr_q + 32'({len_q, 2'b00});
          pix_left_q <= pix_left_q - {2'b00, len_q};
        end
      end
    end
  end

endmodule

// File: tb/tb_drw_wrt_burst.sv
// Bench for drw_wrt_burst: FIFO and AXI slave responders, burst list and data order from a line/page model.
module tb_drw_wrt_burst;
  localparam int BURST_MAX = 16;
  localparam int CNT_W     = 9;

  logic             ACLK = 1'b0;
  logic             ARESETN, RST, START;
  logic [31:0]      DST_ADDR;
  logic [10:0]      DST_WIDTH, DST_HEIGHT;
  logic [15:0]      DST_STRIDE;
  logic             BUSY, DONE, WRT_FIFO_RD, WRT_FIFO_VALID;
  logic [31:0]      WRT_FIFO_DOUT;
  logic [CNT_W-1:0] WRT_FIFO_DATA_CNT, fcnt, cnt_force;
  bit               cnt_force_en;
`ifdef DRW_WRT_ERRLOG_EN
  logic [15:0]      ERR_CNT;
  logic [31:0]      ERR_ADDR;
`endif

  drw_wrt_burst_if axi();

  drw_wrt_burst #(.BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .RST(RST), .START(START),
    .DST_ADDR(DST_ADDR), .DST_WIDTH(DST_WIDTH), .DST_HEIGHT(DST_HEIGHT), .DST_STRIDE(DST_STRIDE),
    .BUSY(BUSY), .DONE(DONE), .WRT_FIFO_RD(WRT_FIFO_RD), .WRT_FIFO_VALID(WRT_FIFO_VALID),
    .WRT_FIFO_DOUT(WRT_FIFO_DOUT), .WRT_FIFO_DATA_CNT(WRT_FIFO_DATA_CNT),
`ifdef DRW_WRT_ERRLOG_EN
    .ERR_CNT(ERR_CNT), .ERR_ADDR(ERR_ADDR),
`endif
    .m_axi(axi)
  );

  always #5 ACLK = ~ACLK;

  int          errors = 0, checks = 0;
  logic [31:0] fq[$], exp_data[$], w_got[$];
  logic [39:0] exp_aw[$], aw_got[$];
  int          exp_wl[$], wl_got[$];
  logic [1:0]  bresp_q[$];
  int          rd_total = 0, done_total = 0, w_beats = 0, beat_in_burst = 0, pend_b = 0;
  bit          rmode = 0, junk_en = 0, rd_seen = 0, wlast_hs = 0, b_hs = 0, tb_clr = 0;

  assign WRT_FIFO_DATA_CNT = cnt_force_en ? cnt_force : fcnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: values at the falling edge are exactly what the next rising edge samples.
  always @(negedge ACLK) begin
    rd_seen  = WRT_FIFO_RD;
    wlast_hs = 1'b0;
    b_hs     = axi.BVALID && axi.BREADY;
    if (axi.AWVALID && axi.AWREADY) aw_got.push_back({axi.AWADDR, axi.AWLEN});
    if (axi.WVALID && axi.WREADY) begin
      w_got.push_back(axi.WDATA);
      w_beats++;
      beat_in_burst++;
      if (axi.WLAST) begin
        wl_got.push_back(beat_in_burst);
        beat_in_burst = 0;
        wlast_hs = 1'b1;
      end
    end
    if (DONE) done_total++;
  end

  // FIFO (data one cycle after RD) and AXI slave responders.
  always @(posedge ACLK) begin
    logic bv;
    if (rd_seen) begin
      rd_total++;
      if (fq.size() > 0) WRT_FIFO_DOUT <= fq.pop_front();
      else               WRT_FIFO_DOUT <= 32'hBAD0BAD0;
      WRT_FIFO_VALID <= 1'b1;
    end else begin
      WRT_FIFO_VALID <= junk_en && ($urandom_range(3) == 0);
      WRT_FIFO_DOUT  <= 32'hDEADBEEF;
    end
    fcnt <= CNT_W'(fq.size());
    axi.AWREADY <= rmode ? 1'($urandom_range(1)) : 1'b1;
    axi.WREADY  <= rmode ? 1'($urandom_range(1)) : 1'b1;
    if (tb_clr) begin
      pend_b = 0;
      axi.BVALID <= 1'b0;
    end else begin
      bv = axi.BVALID && !b_hs;
      if (b_hs) axi.BVALID <= 1'b0;
      if (wlast_hs) pend_b++;
      if (!bv && pend_b > 0 && (!rmode || $urandom_range(1) == 1)) begin
        axi.BVALID <= 1'b1;
        if (bresp_q.size() > 0) axi.BRESP <= bresp_q.pop_front();
        else                    axi.BRESP <= rmode ? 2'($urandom_range(3)) : 2'b00;
        pend_b--;
      end
    end
  end

  // Expected bursts: walk each line, cutting at BURST_MAX and at every 4 KB page edge.
  task automatic prep(input logic [31:0] a, input int w, input int h, input logic [15:0] s);
    logic [31:0] la, ca, d;
    int left, len, room;
    exp_aw.delete(); exp_wl.delete(); exp_data.delete();
    aw_got.delete(); wl_got.delete(); w_got.delete();
    rd_total = 0; w_beats = 0; beat_in_burst = 0;
    la = a;
    for (int y = 0; y < h; y++) begin
      ca = la;
      left = w;
      while (left > 0) begin
        room = (4096 - int'(ca[11:0])) / 4;
        len = left;
        if (len > BURST_MAX) len = BURST_MAX;
        if (room < len) len = room;
        exp_aw.push_back({ca, 8'(len - 1)});
        exp_wl.push_back(len);
        ca = ca + 32'(len * 4);
        left -= len;
      end
      la = la + {16'h0000, s};
    end
    for (int i = 0; i < w * h; i++) begin
      d = $urandom;
      fq.push_back(d);
      exp_data.push_back(d);
    end
  endtask

  task automatic go(input logic [31:0] a, input int w, input int h, input logic [15:0] s);
    @(posedge ACLK); #1;
    START = 1'b1; DST_ADDR = a; DST_WIDTH = 11'(w); DST_HEIGHT = 11'(h); DST_STRIDE = s;
    @(posedge ACLK); #1;
    START = 1'b0; DST_ADDR = $urandom; DST_WIDTH = 11'($urandom); DST_HEIGHT = 11'($urandom);
    DST_STRIDE = 16'($urandom);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge ACLK);
      if (DONE) begin
        seen = 1;
        check({tag, "_busy_at_done"}, BUSY, 1);
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      @(negedge ACLK);
      check({tag, "_idle_after"}, {DONE, BUSY}, 0);
    end
  endtask

  task automatic verify(input string tag);
    int bad;
    repeat (3) @(negedge ACLK);
    check({tag, "_aw_count"}, aw_got.size(), exp_aw.size());
    bad = 0;
    for (int i = 0; i < aw_got.size() && i < exp_aw.size(); i++) if (aw_got[i] !== exp_aw[i]) bad++;
    check({tag, "_aw_mismatches"}, bad, 0);
    check({tag, "_wlast_count"}, wl_got.size(), exp_wl.size());
    bad = 0;
    for (int i = 0; i < wl_got.size() && i < exp_wl.size(); i++) if (wl_got[i] != exp_wl[i]) bad++;
    check({tag, "_burst_len_mismatches"}, bad, 0);
    check({tag, "_beat_count"}, w_got.size(), exp_data.size());
    bad = 0;
    for (int i = 0; i < w_got.size() && i < exp_data.size(); i++) if (w_got[i] !== exp_data[i]) bad++;
    check({tag, "_data_mismatches"}, bad, 0);
    check({tag, "_rd_strobes"}, rd_total, exp_data.size());
    check({tag, "_fifo_left"}, fq.size(), 0);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input int w, input int h,
                     input logic [15:0] s, input bit rm, input bit dup);
    int d0;
    rmode = rm;
    prep(a, w, h, s);
    d0 = done_total;
    go(a, w, h, s);
    check({tag, "_busy_after_start"}, BUSY, 1);
    if (dup) begin
      repeat (2) @(posedge ACLK); #1;
      START = 1'b1; DST_ADDR = 32'h0000_0100; DST_WIDTH = 11'd5; DST_HEIGHT = 11'd2;
      @(posedge ACLK); #1;
      START = 1'b0;
    end
    wait_done(tag, w * h * 40 + 300);
    verify(tag);
    check({tag, "_done_pulses"}, done_total - d0, 1);
  endtask

  initial begin
    int aw_hi, d0;
    bit reached;
    ARESETN = 1'b0; RST = 1'b0; START = 1'b0;
    DST_ADDR = 32'd0; DST_WIDTH = 11'd0; DST_HEIGHT = 11'd0; DST_STRIDE = 16'd0;
    cnt_force_en = 1'b0; cnt_force = '0;
    axi.BVALID = 1'b0; axi.BRESP = 2'b00;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awvalid", axi.AWVALID, 0);
    check("rst_wvalid", axi.WVALID, 0);
    check("rst_bready", axi.BREADY, 0);
    check("rst_rd", WRT_FIFO_RD, 0);
    check("rst_busy_done", {BUSY, DONE}, 0);
    check("rst_awaddr", axi.AWADDR, 0);
    check("rst_awlen", axi.AWLEN, 0);
    check("rst_awsize_burst", {axi.AWSIZE, axi.AWBURST}, 5'b010_01);
    check("rst_wstrb", axi.WSTRB, 4'hF);
    ARESETN = 1'b1;

    run("t1", 32'h0000_1000, 8, 1, 16'h0, 0, 0);
    check("t1_awlen", aw_got[0], {32'h0000_1000, 8'd7});
    check("t1_wlast_beat", wl_got[0], 8);

    run("t2", 32'h0000_0FF8, 20, 1, 16'h0, 0, 0);
    check("t2_b0", aw_got[0], {32'h0000_0FF8, 8'd1});
    check("t2_b1", aw_got[1], {32'h0000_1000, 8'd15});
    check("t2_b2", aw_got[2], {32'h0000_1040, 8'd1});

    run("t3", 32'h0000_2000, 4, 3, 16'h0400, 0, 0);
    check("t3_b2", aw_got[2], {32'h0000_2800, 8'd3});
    check("t3_rd12", rd_total, 12);

    run("t4", 32'h0001_0000, 16, 1, 16'h0, 1, 0);

    // Zero-size rectangle: DONE one cycle later, BUSY never rises.
    prep(32'h0000_9000, 0, 5, 16'h0);
    d0 = done_total;
    go(32'h0000_9000, 0, 5, 16'h0);
    check("t0_done_pulse", {DONE, BUSY}, 2'b10);
    @(posedge ACLK); #1;
    check("t0_done_low", {DONE, BUSY}, 2'b00);
    repeat (3) @(negedge ACLK);
    check("t0_no_aw", aw_got.size(), 0);
    check("t0_one_done", done_total - d0, 1);

    // FIFO short of a full burst: AW must wait for the count.
    rmode = 0;
    prep(32'h0000_3000, 16, 1, 16'h0);
    cnt_force = 9'd10; cnt_force_en = 1'b1;
    go(32'h0000_3000, 16, 1, 16'h0);
    aw_hi = 0;
    repeat (50) begin
      @(negedge ACLK);
      if (axi.AWVALID) aw_hi++;
    end
    check("t5_aw_held", aw_hi, 0);
    @(posedge ACLK); #1;
    cnt_force = 9'd16;
    @(negedge ACLK); check("t5_aw_c0", axi.AWVALID, 0);
    @(negedge ACLK); check("t5_aw_c1", axi.AWVALID, 0);
    @(negedge ACLK); check("t5_aw_c2", axi.AWVALID, 1);
    cnt_force_en = 1'b0;
    wait_done("t5", 800);
    verify("t5");

    // Soft clear mid-burst, then a clean rectangle.
    rmode = 0;
    prep(32'h0000_5000, 16, 1, 16'h0);
    go(32'h0000_5000, 16, 1, 16'h0);
    reached = 0;
    for (int i = 0; i < 400 && !reached; i++) begin
      @(negedge ACLK);
      if (w_beats >= 5) reached = 1;
    end
    check("t6_reached_beat5", reached, 1);
    RST = 1'b1; tb_clr = 1'b1;
    @(negedge ACLK);
    check("t6_cleared", {axi.WVALID, axi.AWVALID, BUSY}, 3'b000);
    RST = 1'b0; tb_clr = 1'b0;
    fq.delete();
    run("t6_after", 32'h0000_6000, 16, 1, 16'h0, 0, 0);

    run("wrap", 32'hFFFF_FFF8, 6, 1, 16'h0, 0, 0);
    check("wrap_b1", aw_got[1], {32'h0000_0000, 8'd3});

`ifdef DRW_WRT_ERRLOG_EN
    bresp_q.push_back(2'b00); bresp_q.push_back(2'b10); bresp_q.push_back(2'b00);
    run("err", 32'h0000_7000, 48, 1, 16'h0, 0, 0);
    check("err_cnt", ERR_CNT, 1);
    check("err_addr", ERR_ADDR, 32'h0000_7040);
    bresp_q.delete();
`endif

    junk_en = 1;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] a;
      a = ($urandom() & 32'hFFFF_F000) | (32'h0000_0F00 + 32'($urandom_range(63)) * 4);
      run($sformatf("rnd%0d", k), a, $urandom_range(1, 40), $urandom_range(1, 3),
          16'($urandom_range(16383) * 4), 1, 1);
    end
    junk_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
